// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: one active-low column at a time, two-flop row sync,
// tick-based press/release debounce, hex encoding and an 8-digit shift register.
module keypad_scan4x4 #(
  parameter int SCAN_DIV     = 32768,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_row,
  input  logic        i_clear,
  output logic [3:0]  o_col,
  output logic        o_key_valid,
  output logic [3:0]  o_key_code,
  output logic        o_key_down,
  output logic [31:0] o_data
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t           state;
  logic [3:0]       rs_meta;
  logic [3:0]       rs;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       captured;

  logic             tick;
  logic [1:0]       col_next;
  logic [3:0]       col_drive;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       new_code;

  function automatic logic is_single(input logic [3:0] p);
    case (p)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: is_single = 1'b1;
      default:                            is_single = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] p);
    case (p)
      4'b1101: row_of = 2'd1;
      4'b1011: row_of = 2'd2;
      4'b0111: row_of = 2'd3;
      default: row_of = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign col_next  = col + 2'd1;
  assign col_drive = ~(4'b0001 << col_next);
  assign cnt_inc   = cnt + 1'b1;
  assign new_code  = key_map(row_of(captured), col);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the synchronizer resets to "no key" so the first ticks after reset see idle rows.
      rs_meta     <= 4'hF;
      rs          <= 4'hF;
      div_cnt     <= '0;
      col         <= 2'd0;
      o_col       <= 4'b1110;
      state       <= SCAN;
      cnt         <= '0;
      captured    <= '0;
      o_key_valid <= 1'b0;
      o_key_code  <= 4'h0;
      o_key_down  <= 1'b0;
      o_data      <= '0;
    end else begin
      // NOTE: every state register uses <= so all reads see pre-edge values.
      rs_meta     <= i_row;
      rs          <= rs_meta;
      o_key_valid <= 1'b0;
      // Columns only change on a tick, where the divider wraps anyway.
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;

      if (tick) begin
        case (state)
          SCAN: begin
            if (is_single(rs)) begin
              captured <= rs;
              cnt      <= CNT_W'(1);
              state    <= DEBOUNCE;
            end else begin
              col   <= col_next;
              o_col <= col_drive;
            end
          end
          DEBOUNCE: begin
            if (rs == captured) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_DONE) begin
                state       <= PRESSED;
                cnt         <= '0;
                o_key_valid <= 1'b1;
                o_key_code  <= new_code;
                o_key_down  <= 1'b1;
                o_data      <= {o_data[27:0], new_code};
              end
            end else begin
              state <= SCAN;
              col   <= col_next;
              o_col <= col_drive;
            end
          end
          PRESSED: begin
            // Release needs DEBOUNCE_CNT consecutive idle ticks; any bounce restarts it.
            if (rs == 4'hF) begin
              if (cnt_inc == CNT_DONE) begin
                state      <= SCAN;
                cnt        <= '0;
                o_key_down <= 1'b0;
                col        <= col_next;
                o_col      <= col_drive;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end

      // Clear overrides a coincident digit shift.
      if (i_clear) o_data <= '0;
    end
  end

endmodule

// File: doc/keypad_scan4x4.md
Name: keypad_scan4x4

Overview:
- Input-side counterpart to the board's 8-digit hex display driver.
- Scans a 4x4 matrix keypad by driving one column low at a time and reading the four rows.
- Debounces each press and encodes it to a hex nibble.
- Shifts entered digits into a 32-bit value, so the 8-digit display can echo it and the CPU can read it as an I/O word.

Parameters:
- SCAN_DIV, 32768: clk cycles per column dwell; one sample tick per dwell. Must be >= 4.
- DEBOUNCE_CNT, 4: consecutive matching ticks needed to confirm a press or a release. Must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_row  in  4  keypad rows, active-low, pulled up externally
- i_clear  in  1  clears o_data (one-cycle strobe)
- o_col  out  4  column drive, active-low, exactly one bit low
- o_key_valid  out  1  one-cycle pulse per confirmed key press
- o_key_code  out  4  code of the last confirmed key; held between presses
- o_key_down  out  1  high while a confirmed key is held (PRESSED state)
- o_data  out  32  last 8 digits entered; newest digit in [3:0]

Behaviour:
- All logic on posedge clk. Reset is synchronous, active-high.
- Reset values:
  - o_col = 4'b1110 (column 0)
  - o_key_valid = 0, o_key_code = 0, o_key_down = 0, o_data = 0
  - state SCAN; divider, debounce counter and captured row pattern = 0
  - both row synchronizer stages = 4'hF
- Row synchronizer: i_row passes through 2 flops (rs).
- Divider: counts 0..SCAN_DIV-1 and wraps. tick = (count == SCAN_DIV-1). The divider resets to 0 whenever the column changes.
- Key map, row r (0 = i_row[0]) and column c (0 = o_col[0]):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- "single" means rs has exactly one zero bit.
- State SCAN:
  - On tick with rs == 4'hF, or with more than one zero: rotate the column (c -> c+1 mod 4, o_col = ~(1<<c)).
  - On tick with single rs: capture rs, set deb = 1, go to DEBOUNCE. The column is held.
- State DEBOUNCE:
  - On tick with rs == captured: deb = deb + 1.
  - When the incremented deb equals DEBOUNCE_CNT, on the same clock edge:
    - go to PRESSED
    - o_key_valid = 1 for exactly that one following cycle
    - o_key_code = map(r, c)
    - o_key_down = 1
    - o_data = {o_data[27:0], code}
  - On tick with rs != captured: return to SCAN and rotate the column. No pulse.
- State PRESSED:
  - Column is held.
  - On tick with rs == 4'hF: rel = rel + 1. On any other tick: rel = 0.
  - When rel reaches DEBOUNCE_CNT: go to SCAN, o_key_down = 0, rotate the column.
  - No further pulses are emitted while held. No auto-repeat.
- Latency: press confirmation occurs on the (DEBOUNCE_CNT-1)th tick after the detection tick. o_key_valid is registered and rises on the edge of that tick.
- i_clear:
  - sets o_data = 0 the next cycle in any state.
  - If coincident with a key confirmation, clear wins and that digit is discarded from o_data. o_key_valid and o_key_code still update.
- Overflow: after 8 digits, the oldest nibble is shifted out of [31:28].
- A second key pressed in another column while in DEBOUNCE or PRESSED is invisible, because that column is not driven.
- Reset mid-operation returns to SCAN at column 0 with no pulse. A key still held is re-detected and reported again after full debounce.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3; the bench models the keypad combinationally from o_col):
- Reset asserted 2 cycles -> o_col=1110, o_data=0, o_key_valid=0, o_key_down=0. With no keys pressed, o_col rotates 1110->1101->1011->0111->1110 every 4 cycles.
- Hold key '5' (r1,c1) for 40 cycles, then release -> exactly one o_key_valid pulse. At that pulse o_key_code=5 and o_data=0x00000005. o_key_down stays high until 3 all-high ticks after release.
- Press/release 1,2,3,A,B,C,D,E,F in sequence -> o_data=0x23ABCDEF after the 9th key; 9 pulses total.
- Hold '8' for only 1 tick (bounce), then release -> no pulse, o_data unchanged, scanning resumes from column 2.
- Press '1' and '7' together (same column 0, rows 0 and 2) -> no pulse, o_col keeps rotating. Separately, assert i_clear on the confirmation cycle of '9' -> o_key_code=9, o_data=0.
- Assert reset while in PRESSED holding '0' -> outputs return to reset values. With '0' still held, one new pulse with code 0 follows after debounce.
